// File: rtl/hazard_ctrl.sv
// Pipeline hazard and bubble controller: load-use stall insertion, EX-resolved
// redirect flushes, syscall halt handling and saturating perf counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_Rw,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             resume,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_nop,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        HALT
    } state_t;

    state_t     state;
    logic [3:0] down_cnt;
    logic       lu;
    logic       stall_inc;
    logic       flush_inc;

    // Load-use hit: EX load targets a nonzero register that ID reads
    always_comb begin
        lu = ex_load && ex_we && (ex_Rw != 5'd0) &&
             ((id_use_rs && (id_rs == ex_Rw)) || (id_use_rt && (id_rt == ex_Rw)));
    end

    // Pipeline controls and counter increment strobes from state and inputs
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_nop   = 1'b0;
        halted     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (rst) begin
            idex_nop = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ex_halt) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_nop   = 1'b1;
                    end else if (ex_redirect) begin
                        // wrong-path ID instruction: any load-use hit is moot
                        ifid_flush = 1'b1;
                        idex_nop   = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (lu) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_nop   = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
                STALL: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_nop   = 1'b1;
                    stall_inc  = 1'b1;
                end
                HALT: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_nop   = 1'b1;
                    halted     = 1'b1;
                end
                default: begin
                    idex_nop = 1'b1;
                end
            endcase
        end
    end

    // State, bubble down-counter and saturating perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            down_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_halt) begin
                        state <= HALT;
                    end else if (!ex_redirect && lu && (LOAD_STALL_CYCLES > 1)) begin
                        down_cnt <= 4'(LOAD_STALL_CYCLES - 1);
                        state    <= STALL;
                    end
                end
                STALL: begin
                    down_cnt <= down_cnt - 4'd1;
                    if (down_cnt == 4'd1) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (N=1/32-bit counters and
// N=3/4-bit counters) share stimulus and are checked against a bubble model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_Rw = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0, ex_we = 1'b0, ex_load = 1'b0;
    logic        ex_redirect = 1'b0, ex_halt = 1'b0, resume = 1'b0;

    logic        a_pc, a_ifs, a_iff, a_nop, a_halt;
    logic [31:0] a_sc, a_fc;
    logic        b_pc, b_ifs, b_iff, b_nop, b_halt;
    logic [3:0]  b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_Rw(ex_Rw),
        .ex_we(ex_we), .ex_load(ex_load), .ex_redirect(ex_redirect),
        .ex_halt(ex_halt), .resume(resume), .pc_stall(a_pc),
        .ifid_stall(a_ifs), .ifid_flush(a_iff), .idex_nop(a_nop),
        .halted(a_halt), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_Rw(ex_Rw),
        .ex_we(ex_we), .ex_load(ex_load), .ex_redirect(ex_redirect),
        .ex_halt(ex_halt), .resume(resume), .pc_stall(b_pc),
        .ifid_stall(b_ifs), .ifid_flush(b_iff), .idex_nop(b_nop),
        .halted(b_halt), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Reference model: halted flag, bubbles still owed, plain integer counters
    int          cfg_n[2]   = '{1, 3};
    longint      cfg_max[2] = '{64'd4294967295, 64'd15};
    bit          m_halt[2];
    int          m_left[2];
    longint      m_sc[2];
    longint      m_fc[2];

    // Samples taken during the last step
    logic [4:0]  s1_ctl, s3_ctl;
    longint      s1_sc, s1_fc, s3_sc, s3_fc;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit lu_hit();
        return ex_load && ex_we && ex_Rw != 0 &&
               ((id_use_rs && id_rs == ex_Rw) || (id_use_rt && id_rt == ex_Rw));
    endfunction

    // Expected {pc_stall, ifid_stall, ifid_flush, idex_nop, halted}
    function automatic logic [4:0] exp_ctl(input int k);
        if (rst)            return 5'b00010;
        if (m_halt[k])      return 5'b11011;
        if (m_left[k] > 0)  return 5'b11010;
        if (ex_halt)        return 5'b11010;
        if (ex_redirect)    return 5'b00110;
        if (lu_hit())       return 5'b11010;
        return 5'b00000;
    endfunction

    function automatic longint sat(input longint v, input int k);
        return (v > cfg_max[k]) ? cfg_max[k] : v;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_halt[k] = 0; m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else if (m_halt[k]) begin
                if (resume) m_halt[k] = 0;
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                m_sc[k] = sat(m_sc[k] + 1, k);
            end else if (ex_halt) begin
                m_halt[k] = 1;
            end else if (ex_redirect) begin
                m_fc[k] = sat(m_fc[k] + 1, k);
            end else if (lu_hit()) begin
                m_sc[k] = sat(m_sc[k] + 1, k);
                m_left[k] = cfg_n[k] - 1;
            end
        end
    endtask

    // One cycle: settle, compare both instances with the model, clock, advance
    task automatic step(input string tag);
        #2;
        s1_ctl = {a_pc, a_ifs, a_iff, a_nop, a_halt};
        s3_ctl = {b_pc, b_ifs, b_iff, b_nop, b_halt};
        s1_sc = longint'(a_sc); s1_fc = longint'(a_fc);
        s3_sc = longint'(b_sc); s3_fc = longint'(b_fc);
        chk({tag, "_n1_ctl"}, longint'(s1_ctl), longint'(exp_ctl(0)));
        chk({tag, "_n1_cnt"}, (s1_sc << 32) | s1_fc, (m_sc[0] << 32) | m_fc[0]);
        chk({tag, "_n3_ctl"}, longint'(s3_ctl), longint'(exp_ctl(1)));
        chk({tag, "_n3_cnt"}, (s3_sc << 8) | s3_fc, (m_sc[1] << 8) | m_fc[1]);
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_Rw = '0; id_use_rs = 0; id_use_rt = 0;
        ex_we = 0; ex_load = 0; ex_redirect = 0; ex_halt = 0; resume = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_load = 1; ex_we = 1; ex_Rw = r; id_use_rs = 1; id_rs = r;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step("rst");
        step("rst");
        rst = 0;
    endtask

    typedef struct {
        logic [4:0] rs, rt, rw;
        logic       use_rs, use_rt, we, load, redir;
        logic [4:0] exp;
    } vec_t;

    vec_t vt[9];
    int   cnt;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0; m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end

        // Reset state and release
        do_reset();
        chk("reset_ctl", longint'(s1_ctl), 5'b00010);
        chk("reset_cnt", s1_sc + s1_fc + s3_sc + s3_fc, 0);
        step("post_rst");
        chk("post_rst_ctl", longint'(s1_ctl), 0);

        // Single-cycle decode vectors against the N=1 instance (always in RUN)
        vt[0] = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 1, 0, 5'b11010};
        vt[1] = '{5'd0, 5'd9, 5'd9, 0, 1, 1, 1, 0, 5'b11010};
        vt[2] = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 0, 5'b00000};
        vt[3] = '{5'd8, 5'd0, 5'd8, 0, 0, 1, 1, 0, 5'b00000};
        vt[4] = '{5'd8, 5'd0, 5'd8, 1, 0, 0, 1, 0, 5'b00000};
        vt[5] = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 0, 0, 5'b00000};
        vt[6] = '{5'd8, 5'd7, 5'd9, 1, 1, 1, 1, 0, 5'b00000};
        vt[7] = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 1, 1, 5'b00110};
        vt[8] = '{5'd3, 5'd4, 5'd5, 0, 0, 0, 0, 1, 5'b00110};
        for (int i = 0; i < 9; i++) begin
            id_rs = vt[i].rs; id_rt = vt[i].rt; ex_Rw = vt[i].rw;
            id_use_rs = vt[i].use_rs; id_use_rt = vt[i].use_rt;
            ex_we = vt[i].we; ex_load = vt[i].load; ex_redirect = vt[i].redir;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl", i), longint'(s1_ctl), longint'(vt[i].exp));
            idle_inputs();
            for (int j = 0; j < 3; j++) step("vec_gap");
        end

        // Load-use hit, N=1 vs N=3 bubble length
        do_reset();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) set_lu(5'd8); else idle_inputs();
            step("lu_len");
            if (s3_ctl[4]) cnt++;
        end
        chk("n3_bubble_len", cnt, 3);
        chk("n3_stall_cnt", s3_sc, 3);
        chk("n1_stall_cnt", s1_sc, 1);
        set_lu(5'd0);
        step("rw0");
        chk("rw0_no_stall", longint'(s3_ctl), 0);
        idle_inputs();

        // Redirect together with a load-use hit
        do_reset();
        set_lu(5'd8); ex_redirect = 1;
        step("redir_lu");
        chk("redir_lu_ctl", longint'(s1_ctl), 5'b00110);
        idle_inputs();
        step("redir_lu2");
        chk("redir_lu_fc", s1_fc, 1);
        chk("redir_lu_sc", s3_sc, 0);

        // Halt held while redirects toggle, then resume
        do_reset();
        ex_halt = 1;
        step("halt_in");
        ex_halt = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            ex_redirect = i[0];
            if (i == 4) set_lu(5'd6); else begin ex_load = 0; end
            step("halt_hold");
            if (s1_ctl == 5'b11011 && s3_ctl == 5'b11011) cnt++;
        end
        chk("halt_hold_cycles", cnt, 10);
        idle_inputs();
        resume = 1;
        step("halt_resume");
        chk("halt_resume_cycle", longint'(s1_ctl), 5'b11011);
        resume = 0;
        step("halt_exit");
        chk("halt_exit_ctl", longint'(s1_ctl), 0);
        chk("halt_frozen_cnt", s1_sc + s1_fc, 0);

        // Flush counter saturation on the 4-bit instance
        do_reset();
        ex_redirect = 1;
        for (int i = 0; i < 20; i++) step("sat");
        idle_inputs();
        step("sat_end");
        chk("sat_fc4", s3_fc, 15);
        chk("sat_fc32", s1_fc, 20);

        // Reset in the middle of an N=3 stall
        do_reset();
        set_lu(5'd8);
        step("rst_mid_lu");
        idle_inputs();
        rst = 1;
        step("rst_mid");
        chk("rst_mid_ctl", longint'(s3_ctl), 5'b00010);
        rst = 0;
        step("rst_mid_after");
        chk("rst_mid_after_ctl", longint'(s3_ctl), 0);
        chk("rst_mid_after_cnt", s3_sc, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 39) == 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_Rw       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            ex_we       = ($urandom_range(0, 3) != 0);
            ex_load     = ($urandom_range(0, 2) != 0);
            ex_redirect = ($urandom_range(0, 4) == 0);
            ex_halt     = ($urandom_range(0, 24) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            step("rand");
        end
        rst = 0;
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
